// File: rtl/dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbg_pkg
// Description : Shared types and constants for the debug run/halt/step
//               controller (run-state encoding and halt-cause codes).
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_pkg;

    // Width of the halt-cause code reported to the debug front-end
    localparam int CAUSE_W = 2;

    // Controller run state
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } dbg_state_e;

    // Halt-cause codes
    localparam logic [CAUSE_W-1:0] CAUSE_NONE  = 2'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_DEBUG = 2'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_STEP  = 2'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BP    = 2'd3;

endpackage : dbg_pkg
`default_nettype wire

// File: rtl/dbg_bp_match.sv
`default_nettype none
// ============================================================================
// Module      : dbg_bp_match
// Description : Breakpoint slot register file with parallel PC comparators
//               and a lowest-index priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_bp_match #(
    parameter int XLEN     = 32,
    parameter int NUM_BP   = 4,
    parameter int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bp_wr_en,
    input  logic [BP_IDX_W-1:0] bp_wr_idx,
    input  logic [XLEN-1:0]     bp_wr_addr,
    input  logic                bp_wr_valid,
    input  logic [XLEN-1:0]     pc_if,
    output logic                hit,
    output logic [BP_IDX_W-1:0] hit_idx
);

    logic [XLEN-1:0]   slot_addr_q [NUM_BP];
    logic [XLEN-1:0]   slot_addr_d [NUM_BP];
    logic [NUM_BP-1:0] slot_valid_q;
    logic [NUM_BP-1:0] slot_valid_d;
    logic [NUM_BP-1:0] match;

    // Slot write decode; an index with no matching slot writes nothing
    always_comb begin
        slot_valid_d = slot_valid_q;
        for (int i = 0; i < NUM_BP; i++) begin
            slot_addr_d[i] = slot_addr_q[i];
            if (bp_wr_en && (bp_wr_idx == BP_IDX_W'(i))) begin
                slot_addr_d[i]  = bp_wr_addr;
                slot_valid_d[i] = bp_wr_valid;
            end
        end
    end

    // Slot storage; reset leaves every slot invalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                slot_addr_q[i] <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int i = 0; i < NUM_BP; i++) begin
                slot_addr_q[i] <= slot_addr_d[i];
            end
        end
    end

    // One comparator per slot, compared against the stored (not incoming) value
    generate
        for (genvar g = 0; g < NUM_BP; g++) begin : g_cmp
            assign match[g] = slot_valid_q[g] && (slot_addr_q[g] == pc_if);
        end
    endgenerate

    // Lowest matching slot wins: scan from the top so lower indices overwrite
    always_comb begin
        hit_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_idx = BP_IDX_W'(i);
            end
        end
    end

    assign hit = |match;

endmodule : dbg_bp_match
`default_nettype wire

// File: rtl/dbg_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dbg_run_ctrl
// Description : Run/halt/step controller producing the core advance enable,
//               with N-instruction stepping, PC breakpoints, halt-cause
//               reporting and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_run_ctrl #(
    parameter int XLEN     = 32,
    parameter int NUM_BP   = 4,
    parameter int STEP_W   = 16,
    parameter int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                debug_en,
    input  logic                debug_step,
    input  logic [STEP_W-1:0]   step_count,
    input  logic                bp_wr_en,
    input  logic [BP_IDX_W-1:0] bp_wr_idx,
    input  logic [XLEN-1:0]     bp_wr_addr,
    input  logic                bp_wr_valid,
    input  logic [XLEN-1:0]     pc_if,
    input  logic                instr_retire,
    output logic                core_en,
    output logic                halted,
    output logic [1:0]          halt_cause,
    output logic [BP_IDX_W-1:0] bp_hit_idx,
    output logic [STEP_W-1:0]   steps_left,
    output logic [XLEN-1:0]     retire_cnt
);

    import dbg_pkg::*;

    dbg_state_e           state_q,      state_d;
    logic                 halted_q,     halted_d;
    logic [CAUSE_W-1:0]   cause_q,      cause_d;
    logic [BP_IDX_W-1:0]  bp_hit_idx_q, bp_hit_idx_d;
    logic [STEP_W-1:0]    steps_left_q, steps_left_d;
    logic [XLEN-1:0]      retire_cnt_q, retire_cnt_d;
    logic                 step_q;
    logic                 suppress_q,   suppress_d;

    logic                 bp_hit;
    logic [BP_IDX_W-1:0]  bp_idx;
    logic                 bp_fire;
    logic                 step_rise;
    logic                 retire_ok;

    dbg_bp_match #(
        .XLEN     (XLEN),
        .NUM_BP   (NUM_BP),
        .BP_IDX_W (BP_IDX_W)
    ) u_bp_match (
        .clk         (clk),
        .rst_n       (rst_n),
        .bp_wr_en    (bp_wr_en),
        .bp_wr_idx   (bp_wr_idx),
        .bp_wr_addr  (bp_wr_addr),
        .bp_wr_valid (bp_wr_valid),
        .pc_if       (pc_if),
        .hit         (bp_hit),
        .hit_idx     (bp_idx)
    );

    // A breakpoint stalls the matching instruction in the same cycle; suppress
    // keeps the resume PC from re-triggering until one instruction retires
    assign bp_fire   = (state_q != ST_HALT) && !suppress_q && bp_hit;
    assign core_en   = (state_q != ST_HALT) && !bp_fire;
    assign step_rise = debug_step && !step_q;
    assign retire_ok = instr_retire && core_en;

    // Next-state, cause, step counter and retire counter logic
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        bp_hit_idx_d = bp_hit_idx_q;
        steps_left_d = steps_left_q;
        suppress_d   = suppress_q;

        if (retire_ok) begin
            suppress_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (bp_fire) begin
                    state_d      = ST_HALT;
                    cause_d      = CAUSE_BP;
                    bp_hit_idx_d = bp_idx;
                end else if (debug_en) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_DEBUG;
                end
            end
            ST_HALT: begin
                if (!debug_en) begin
                    state_d    = ST_RUN;
                    suppress_d = 1'b1;
                end else if (step_rise) begin
                    state_d      = ST_STEP;
                    steps_left_d = (step_count == '0) ? STEP_W'(1) : step_count;
                    suppress_d   = 1'b1;
                end
            end
            ST_STEP: begin
                if (!debug_en) begin
                    state_d      = ST_RUN;
                    steps_left_d = '0;
                end else if (bp_fire) begin
                    state_d      = ST_HALT;
                    cause_d      = CAUSE_BP;
                    bp_hit_idx_d = bp_idx;
                end else if (retire_ok) begin
                    if (steps_left_q == STEP_W'(1)) begin
                        state_d      = ST_HALT;
                        cause_d      = CAUSE_STEP;
                        steps_left_d = '0;
                    end else begin
                        steps_left_d = steps_left_q - STEP_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        halted_d     = (state_d == ST_HALT);
        retire_cnt_d = retire_ok ? (retire_cnt_q + XLEN'(1)) : retire_cnt_q;
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            halted_q     <= 1'b0;
            cause_q      <= CAUSE_NONE;
            bp_hit_idx_q <= '0;
            steps_left_q <= '0;
            retire_cnt_q <= '0;
            step_q       <= 1'b0;
            suppress_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            halted_q     <= halted_d;
            cause_q      <= cause_d;
            bp_hit_idx_q <= bp_hit_idx_d;
            steps_left_q <= steps_left_d;
            retire_cnt_q <= retire_cnt_d;
            step_q       <= debug_step;
            suppress_q   <= suppress_d;
        end
    end

    assign halted     = halted_q;
    assign halt_cause = cause_q;
    assign bp_hit_idx = bp_hit_idx_q;
    assign steps_left = steps_left_q;
    assign retire_cnt = retire_cnt_q;

endmodule : dbg_run_ctrl
`default_nettype wire

// File: tb/tb_dbg_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbg_run_ctrl
// Description : Directed self-checking bench for dbg_run_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbg_run_ctrl;

    localparam int XLEN     = 32;
    localparam int NUM_BP   = 4;
    localparam int STEP_W   = 16;
    localparam int BP_IDX_W = 2;

    logic                clk;
    logic                rst_n;
    logic                debug_en;
    logic                debug_step;
    logic [STEP_W-1:0]   step_count;
    logic                bp_wr_en;
    logic [BP_IDX_W-1:0] bp_wr_idx;
    logic [XLEN-1:0]     bp_wr_addr;
    logic                bp_wr_valid;
    logic [XLEN-1:0]     pc_if;
    logic                instr_retire;
    logic                core_en;
    logic                halted;
    logic [1:0]          halt_cause;
    logic [BP_IDX_W-1:0] bp_hit_idx;
    logic [STEP_W-1:0]   steps_left;
    logic [XLEN-1:0]     retire_cnt;

    int checks   = 0;
    int failures = 0;

    dbg_run_ctrl #(
        .XLEN     (XLEN),
        .NUM_BP   (NUM_BP),
        .STEP_W   (STEP_W),
        .BP_IDX_W (BP_IDX_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .debug_en     (debug_en),
        .debug_step   (debug_step),
        .step_count   (step_count),
        .bp_wr_en     (bp_wr_en),
        .bp_wr_idx    (bp_wr_idx),
        .bp_wr_addr   (bp_wr_addr),
        .bp_wr_valid  (bp_wr_valid),
        .pc_if        (pc_if),
        .instr_retire (instr_retire),
        .core_en      (core_en),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .bp_hit_idx   (bp_hit_idx),
        .steps_left   (steps_left),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are changed 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bp_write(input int idx, input logic [XLEN-1:0] addr, input logic vld);
        bp_wr_en    = 1'b1;
        bp_wr_idx   = BP_IDX_W'(idx);
        bp_wr_addr  = addr;
        bp_wr_valid = vld;
        tick();
        bp_wr_en    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; debug_en = 1'b0; debug_step = 1'b0; step_count = '0;
        bp_wr_en = 1'b0; bp_wr_idx = '0; bp_wr_addr = '0; bp_wr_valid = 1'b0;
        pc_if = 32'h100; instr_retire = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_halted",  64'(halted),     64'd0);
        chk("rst_cause",   64'(halt_cause), 64'd0);
        chk("rst_steps",   64'(steps_left), 64'd0);
        chk("rst_retire",  64'(retire_cnt), 64'd0);
        chk("rst_idx",     64'(bp_hit_idx), 64'd0);
        rst_n = 1'b1;
        tick();

        // Free run: 10 retires
        instr_retire = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("run_core_en", 64'(core_en), 64'd1);
            tick();
        end
        instr_retire = 1'b0;
        chk("run_retire10", 64'(retire_cnt), 64'd10);
        chk("run_halted",   64'(halted),     64'd0);

        // Debug halt request
        debug_en = 1'b1;
        tick();
        #1;
        chk("dbg_halted",  64'(halted),     64'd1);
        chk("dbg_cause",   64'(halt_cause), 64'd1);
        chk("dbg_core_en", 64'(core_en),    64'd0);

        // Step burst of 3 with retire every cycle
        step_count = 16'd3; debug_step = 1'b1; instr_retire = 1'b1;
        tick();
        #1;
        chk("s3_load",     64'(steps_left), 64'd3);
        chk("s3_core_en",  64'(core_en),    64'd1);
        chk("s3_retire0",  64'(retire_cnt), 64'd10);
        tick();
        chk("s3_steps2",   64'(steps_left), 64'd2);
        tick(); tick();
        #1;
        chk("s3_halted",   64'(halted),     64'd1);
        chk("s3_cause",    64'(halt_cause), 64'd2);
        chk("s3_steps0",   64'(steps_left), 64'd0);
        chk("s3_retire",   64'(retire_cnt), 64'd13);
        chk("s3_core_en0", 64'(core_en),    64'd0);
        debug_step = 1'b0; instr_retire = 1'b0;
        tick();

        // step_count = 0 behaves as a single step
        step_count = 16'd0; debug_step = 1'b1; instr_retire = 1'b1;
        tick();
        chk("s0_load",    64'(steps_left), 64'd1);
        tick();
        chk("s0_halted",  64'(halted),     64'd1);
        chk("s0_cause",   64'(halt_cause), 64'd2);
        chk("s0_retire",  64'(retire_cnt), 64'd14);
        tick();
        chk("s0_no_more", 64'(retire_cnt), 64'd14);
        debug_step = 1'b0; instr_retire = 1'b0;

        // Breakpoint at 0x40 in slot 2
        bp_write(2, 32'h40, 1'b1);
        pc_if = 32'h3c; debug_en = 1'b0; instr_retire = 1'b1;
        tick();                         // HALT -> RUN, suppress set
        chk("bp_resume_halted", 64'(halted), 64'd0);
        tick();                         // retire at 0x3c clears suppress
        chk("bp_retire15", 64'(retire_cnt), 64'd15);
        pc_if = 32'h40; debug_en = 1'b1;
        #1;
        chk("bp_core_en0", 64'(core_en), 64'd0);
        tick();
        chk("bp_halted",   64'(halted),     64'd1);
        chk("bp_cause",    64'(halt_cause), 64'd3);
        chk("bp_idx2",     64'(bp_hit_idx), 64'd2);
        chk("bp_retire",   64'(retire_cnt), 64'd15);

        // Step off the breakpoint: no re-fire at the same PC
        step_count = 16'd1; debug_step = 1'b1;
        tick();
        #1;
        chk("bp_step_core_en", 64'(core_en), 64'd1);
        tick();
        chk("bp_step_cause",   64'(halt_cause), 64'd2);
        chk("bp_step_halted",  64'(halted),     64'd1);
        chk("bp_step_retire",  64'(retire_cnt), 64'd16);
        debug_step = 1'b0; instr_retire = 1'b0;
        tick();

        // Two slots match: lowest index reported
        bp_write(1, 32'h80, 1'b1);
        bp_write(3, 32'h80, 1'b1);
        pc_if = 32'h7c; debug_en = 1'b0; instr_retire = 1'b1;
        tick(); tick();
        pc_if = 32'h80; debug_en = 1'b1;
        tick();
        chk("pri_cause", 64'(halt_cause), 64'd3);
        chk("pri_idx1",  64'(bp_hit_idx), 64'd1);
        chk("pri_retire", 64'(retire_cnt), 64'd17);
        instr_retire = 1'b0;

        // Invalidate slot 1: next hit at 0x80 reports slot 3
        bp_write(1, 32'h80, 1'b0);
        pc_if = 32'h7c; debug_en = 1'b0; instr_retire = 1'b1;
        tick(); tick();
        pc_if = 32'h80; debug_en = 1'b1;
        tick();
        chk("inv_cause", 64'(halt_cause), 64'd3);
        chk("inv_idx3",  64'(bp_hit_idx), 64'd3);
        chk("inv_retire", 64'(retire_cnt), 64'd18);
        instr_retire = 1'b0;

        // Reset in the middle of a 5-step burst
        pc_if = 32'h200; step_count = 16'd5; debug_step = 1'b1;
        tick();
        chk("rs_steps5", 64'(steps_left), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("rs_steps0",  64'(steps_left), 64'd0);
        chk("rs_halted",  64'(halted),     64'd0);
        chk("rs_core_en", 64'(core_en),    64'd1);
        tick();
        rst_n = 1'b1; debug_en = 1'b0; debug_step = 1'b0;
        pc_if = 32'h40; instr_retire = 1'b1;
        #1;
        chk("rs_no_bp_core_en", 64'(core_en), 64'd1);
        tick();
        chk("rs_no_bp_halted", 64'(halted),     64'd0);
        chk("rs_retire1",      64'(retire_cnt), 64'd1);

        // Drop debug_en in the middle of a step burst
        debug_en = 1'b1;
        tick();                         // RUN retire counts, then HALT
        chk("de_halted", 64'(halted), 64'd1);
        instr_retire = 1'b0; step_count = 16'd5; debug_step = 1'b1;
        tick();
        chk("de_steps5", 64'(steps_left), 64'd5);
        instr_retire = 1'b1;
        tick();
        chk("de_steps4", 64'(steps_left), 64'd4);
        debug_en = 1'b0;
        tick();
        #1;
        chk("de_steps0",  64'(steps_left), 64'd0);
        chk("de_halted0", 64'(halted),     64'd0);
        chk("de_core_en", 64'(core_en),    64'd1);
        chk("de_retire",  64'(retire_cnt), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dbg_run_ctrl
`default_nettype wire
